// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller with blanking, leading-zero suppression and frame-aligned updates
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    load,
   input  logic                    lz_en,
   output logic [3:0]              nibble,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    seg_off,
   output logic                    load_ack,
   output logic                    frame_start
);
   localparam int MAXC = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int VW   = 4 * NUM_DIGITS;
   typedef enum logic {BLANK, SHOW} state_t;
   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [IW-1:0]   idx, idx_n;
   logic [VW-1:0]   active, active_n, shadow;
   logic            pending, run, done, wrap, commit, supp;
   // next scan position, frame-boundary commit and suppression of the digit about to be shown
   always_comb begin
      done     = state == BLANK ? cnt == CW'(BLANK_CYCLES - 1) : cnt == CW'(REFRESH_DIV - 1);
      wrap     = run && done && state == SHOW && idx == IW'(NUM_DIGITS - 1);
      commit   = wrap && (load || pending);
      active_n = commit ? (load ? value_in : shadow) : active;
      state_n  = run && done ? (state == BLANK ? SHOW : BLANK) : state;
      cnt_n    = !run || done ? '0 : cnt + CW'(1);
      idx_n    = run && done && state == SHOW ? (idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1)) : idx;
      supp     = lz_en && idx_n != '0 && (active_n >> (4 * idx_n)) == '0;
   end
   // state, value registers and registered outputs; the first cycle after reset release starts frame 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BLANK;
         cnt         <= '0;
         idx         <= '0;
         active      <= '0;
         shadow      <= '0;
         pending     <= 1'b0;
         run         <= 1'b0;
         nibble      <= '0;
         an          <= '1;
         seg_off     <= 1'b1;
         load_ack    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         active      <= active_n;
         run         <= 1'b1;
         shadow      <= load ? value_in : shadow;
         pending     <= commit ? 1'b0 : (load ? 1'b1 : pending);
         load_ack    <= commit;
         frame_start <= !run || wrap;
         if (!run || (done && state == SHOW)) nibble <= active_n[4*idx_n +: 4];
         an          <= state_n == SHOW ? ~(NUM_DIGITS'(1) << idx_n) : '1;
         seg_off     <= state_n != SHOW || supp;
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed checks of seg_scan_ctrl against a frame-arithmetic reference model
module tb_seg_scan_ctrl;
   localparam int N = 4, R = 4, B = 2, F = N * (B + R);
   logic clk = 1'b0, rst = 1'b1, load = 1'b0, lz_en = 1'b0;
   logic [15:0] value_in = '0;
   logic [3:0] nibble, an;
   logic seg_off, load_ack, frame_start;
   logic [10:0] got_v, exp_v;
   logic [15:0] m_act, m_sh;
   logic m_pend, m_ack;
   int t = -1, n_cmp = 0, n_bad = 0;

   seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst(rst), .value_in(value_in), .load(load), .lz_en(lz_en),
      .nibble(nibble), .an(an), .seg_off(seg_off), .load_ack(load_ack), .frame_start(frame_start));

   always #5 clk = ~clk;

   task automatic tick();
      logic r, l, lz, show, supp;
      logic [15:0] v, hi;
      int p, d;
      r = rst; l = load; lz = lz_en; v = value_in;
      @(posedge clk); #1;
      if (r) begin
         t = -1; m_act = '0; m_sh = '0; m_pend = 1'b0; m_ack = 1'b0;
      end else begin
         t++;
         m_ack = 1'b0;
         if (t > 0 && t % F == 0 && (l || m_pend)) begin
            m_act = l ? v : m_sh; m_pend = 1'b0; m_ack = 1'b1;
         end else if (l) begin
            m_sh = v; m_pend = 1'b1;
         end
      end
      if (t < 0) exp_v = {4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
      else begin
         p = t % F;
         d = p / (B + R);
         show = (p % (B + R)) >= B;
         hi = m_act >> (4 * d);
         supp = lz && d > 0 && hi == '0;
         exp_v = {show ? ~(4'b1 << d) : 4'hF, m_act[4*d +: 4], !show || supp, m_ack, p == 0};
      end
      got_v = {an, nibble, seg_off, load_ack, frame_start};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         tick(); n_cmp++;
         if (got_v !== exp_v) begin n_bad++; $display("FAIL reset: got %b want %b", got_v, exp_v); end
      end
      rst = 1'b0;
      repeat (2 * F) begin
         tick(); n_cmp++;
         if (got_v !== exp_v) begin n_bad++; $display("FAIL scan t=%0d: got %b want %b", t, got_v, exp_v); end
      end
   endtask

   task automatic test_load_commit();
      int acks = 0;
      while (t % F != 10) begin
         tick(); n_cmp++;
         if (got_v !== exp_v) begin n_bad++; $display("FAIL commit_pre t=%0d: got %b want %b", t, got_v, exp_v); end
      end
      load = 1'b1; value_in = 16'h1A3F;
      tick(); load = 1'b0;
      repeat (30) begin
         tick(); n_cmp++; acks += int'(load_ack);
         if (got_v !== exp_v) begin n_bad++; $display("FAIL commit t=%0d: got %b want %b", t, got_v, exp_v); end
      end
      n_cmp++;
      if (acks != 1) begin n_bad++; $display("FAIL commit_ack_count: got %0d want 1", acks); end
   endtask

   task automatic test_lz();
      logic [15:0] vals [2] = '{16'h0050, 16'h0000};
      lz_en = 1'b1;
      foreach (vals[k]) begin
         load = 1'b1; value_in = vals[k];
         tick(); load = 1'b0;
         repeat (2 * F + 5) begin
            tick(); n_cmp++;
            if (got_v !== exp_v) begin n_bad++; $display("FAIL lz %h t=%0d: got %b want %b", vals[k], t, got_v, exp_v); end
         end
      end
      lz_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      while (t % F != 3) tick();
      load = 1'b1; value_in = 16'h1111;
      tick(); load = 1'b0;
      while (t % F != 8) begin
         tick(); n_cmp++;
         if (got_v !== exp_v) begin n_bad++; $display("FAIL dbl t=%0d: got %b want %b", t, got_v, exp_v); end
      end
      load = 1'b1; value_in = 16'h2222;
      tick(); load = 1'b0;
      repeat (F) begin
         tick(); n_cmp++; acks += int'(load_ack);
         if (got_v !== exp_v) begin n_bad++; $display("FAIL dbl t=%0d: got %b want %b", t, got_v, exp_v); end
      end
      while ((t + 1) % F != 0) tick();
      load = 1'b1; value_in = 16'h3333;
      tick(); load = 1'b0; acks += int'(load_ack);
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL coincide t=%0d: got %b want %b", t, got_v, exp_v); end
      repeat (F + 4) begin
         tick(); n_cmp++; acks += int'(load_ack);
         if (got_v !== exp_v) begin n_bad++; $display("FAIL coincide t=%0d: got %b want %b", t, got_v, exp_v); end
      end
      n_cmp++;
      if (acks != 2) begin n_bad++; $display("FAIL dbl_ack_count: got %0d want 2", acks); end
   endtask

   task automatic test_reset_mid();
      while (t % F != 2) tick();
      load = 1'b1; value_in = 16'h9876;
      tick(); load = 1'b0;
      while (t % F != 15) tick();
      rst = 1'b1;
      tick(); rst = 1'b0; n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL rst_mid: got %b want %b", got_v, exp_v); end
      repeat (2 * F) begin
         tick(); n_cmp++;
         if (got_v !== exp_v) begin n_bad++; $display("FAIL rst_restart t=%0d: got %b want %b", t, got_v, exp_v); end
      end
   endtask

   task automatic test_random();
      repeat (400) begin
         load = $urandom_range(0, 7) == 0;
         value_in = 16'($urandom);
         lz_en = 1'($urandom);
         rst = $urandom_range(0, 149) == 0;
         tick(); n_cmp++;
         if (got_v !== exp_v) begin n_bad++; $display("FAIL random t=%0d: got %b want %b", t, got_v, exp_v); end
      end
      load = 1'b0; rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_commit();
      test_lz();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
